// File: rtl/load_store_unit_pkg.sv
// Shared types and helpers for the load/store unit: funct3 size codes,
// FSM state encoding and the access-size decode.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_t;

    // Bytes touched by an access; the unsigned variants share size with the signed ones.
    function automatic logic [3:0] access_bytes(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   access_bytes = 4'd1;
            2'b01:   access_bytes = 4'd2;
            2'b10:   access_bytes = 4'd4;
            default: access_bytes = 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake from execute plus the doubleword memory port.
// master = execute stage + memory, slave = load/store unit.
interface lsu_if #(parameter int ADDR_W = 64);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [63:0]       req_wdata;
    logic              resp_valid;
    logic [63:0]       resp_rdata;
    logic              resp_err;
    logic              MemRead;
    logic              MemWrite;
    logic [ADDR_W-1:0] mem_addr;
    logic [63:0]       mem_wdata;
    logic [63:0]       mem_rdata;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               MemRead, MemWrite, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               MemRead, MemWrite, mem_addr, mem_wdata
    );
endinterface

// File: rtl/load_store_unit_data_align.sv
// Byte-lane alignment: load extract/extend, sub-word store merge, misalignment check.
// Latency: purely combinational.
// Backpressure: none; pure function of its inputs.
module lsu_data_align
    import lsu_pkg::*;
(
    input  logic [63:0] hold,
    input  logic [2:0]  offset,
    input  logic [2:0]  funct3,
    input  logic [63:0] wdata,
    output logic [63:0] load_ext,
    output logic [63:0] store_merged,
    output logic        misaligned
);
    logic [3:0]  size;
    logic [2:0]  align_mask;
    logic [5:0]  shamt;
    logic [63:0] field;
    logic [63:0] byte_mask;

    assign size       = access_bytes(funct3);
    assign align_mask = 3'(size - 4'd1);
    assign misaligned = |(offset & align_mask);
    assign shamt      = {offset, 3'b000};
    assign field      = hold >> shamt;

    // A full doubleword mask can't come from the shift (1 << 64 overflows).
    assign byte_mask    = (size == 4'd8) ? '1 : ((64'd1 << {size, 3'b000}) - 64'd1);
    assign store_merged = (hold & ~(byte_mask << shamt)) | ((wdata & byte_mask) << shamt);

    always_comb begin
        load_ext = field;
        case (funct3)
            F3_B:    load_ext = {{56{field[7]}},  field[7:0]};
            F3_H:    load_ext = {{48{field[15]}}, field[15:0]};
            F3_W:    load_ext = {{32{field[31]}}, field[31:0]};
            F3_BU:   load_ext = {56'd0, field[7:0]};
            F3_HU:   load_ext = {48'd0, field[15:0]};
            F3_WU:   load_ext = {32'd0, field[31:0]};
            default: load_ext = field;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator with read-modify-write for sub-word stores.
// Latency: error 1, load 2, SD 2, SB/SH/SW 3 cycles from acceptance to resp_valid.
// Backpressure: req_ready only in IDLE; response is a one-cycle pulse, never stalled.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic clk,
    input  logic rst,
    lsu_if.slave bus
);
    typedef struct packed {
        logic              write;
        logic [2:0]        funct3;
        logic [ADDR_W-1:0] addr;
        logic [63:0]       wdata;
    } req_t;

    lsu_state_t  state, state_nxt;
    req_t        req_q;
    logic [63:0] hold;
    logic [63:0] resp_rdata_q;
    logic        resp_err_q;

    logic        accept;
    logic        illegal;
    logic        req_err;
    logic [2:0]  al_offset;
    logic [2:0]  al_funct3;
    logic [63:0] al_hold;
    logic [63:0] load_ext;
    logic [63:0] store_merged;
    logic        misaligned;

    // In IDLE the aligner checks the incoming request; afterwards it works on the latched one.
    // During RD the live memory word is used so the load result is ready at the RD->RESP edge.
    assign al_offset = (state == ST_IDLE) ? bus.req_addr[2:0] : req_q.addr[2:0];
    assign al_funct3 = (state == ST_IDLE) ? bus.req_funct3    : req_q.funct3;
    assign al_hold   = (state == ST_RD)   ? bus.mem_rdata     : hold;

    lsu_data_align u_align (
        .hold         (al_hold),
        .offset       (al_offset),
        .funct3       (al_funct3),
        .wdata        (req_q.wdata),
        .load_ext     (load_ext),
        .store_merged (store_merged),
        .misaligned   (misaligned)
    );

    assign bus.req_ready = (state == ST_IDLE) && !rst;
    assign accept        = bus.req_valid && bus.req_ready;
    assign illegal       = bus.req_write ? bus.req_funct3[2] : (bus.req_funct3 == 3'b111);
    assign req_err       = illegal || misaligned;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) begin
                if (req_err)
                    state_nxt = ST_RESP;
                else if (bus.req_write && bus.req_funct3 == F3_D)
                    state_nxt = ST_WR;
                else
                    state_nxt = ST_RD;
            end
            ST_RD:   state_nxt = req_q.write ? ST_WR : ST_RESP;
            ST_WR:   state_nxt = ST_RESP;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            req_q        <= '0;
            hold         <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state        <= state_nxt;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            if (accept) begin
                req_q <= '{write: bus.req_write, funct3: bus.req_funct3,
                           addr: bus.req_addr, wdata: bus.req_wdata};
                resp_err_q <= req_err;
            end
            if (state == ST_RD) begin
                hold <= bus.mem_rdata;
                if (!req_q.write)
                    resp_rdata_q <= load_ext;
            end
        end
    end

    // Enables are gated by rst so an in-flight write is withdrawn before the next edge.
    assign bus.MemRead    = (state == ST_RD) && !rst;
    assign bus.MemWrite   = (state == ST_WR) && !rst;
    assign bus.mem_addr   = (bus.MemRead || bus.MemWrite) ? {req_q.addr[ADDR_W-1:3], 3'b000} : '0;
    assign bus.mem_wdata  = bus.MemWrite ? store_merged : '0;
    assign bus.resp_valid = (state == ST_RESP);
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 16-doubleword memory model.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    lsu_if #(.ADDR_W(64)) bus ();

    load_store_unit #(.ADDR_W(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [63:0] mem [0:15];

    always @(posedge clk)
        if (bus.MemWrite) mem[bus.mem_addr[6:3]] <= bus.mem_wdata;

    assign bus.mem_rdata = bus.MemRead ? mem[bus.mem_addr[6:3]] : 64'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ready"}, {63'd0, bus.req_ready}, 64'd0);
        chk({tag, "_rvld"},  {63'd0, bus.resp_valid}, 64'd0);
        chk({tag, "_rdata"}, bus.resp_rdata, 64'd0);
        chk({tag, "_err"},   {63'd0, bus.resp_err}, 64'd0);
        chk({tag, "_mrd"},   {63'd0, bus.MemRead}, 64'd0);
        chk({tag, "_mwr"},   {63'd0, bus.MemWrite}, 64'd0);
        chk({tag, "_maddr"}, bus.mem_addr, 64'd0);
        chk({tag, "_mwdat"}, bus.mem_wdata, 64'd0);
    endtask

    // Issue one request at a negedge and follow it cycle by cycle until after its response.
    task automatic run(input string tag, input logic w, input logic [2:0] f3,
                       input logic [63:0] a, input logic [63:0] wd, input int lat,
                       input logic [63:0] exp_rdata, input logic exp_err,
                       input int exp_rd, input int exp_wr, input logic [63:0] exp_mwd);
        int nrd;
        int nwr;
        nrd = 0;
        nwr = 0;
        chk({tag, "_ready"}, {63'd0, bus.req_ready}, 64'd1);
        bus.req_valid  = 1'b1;
        bus.req_write  = w;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        @(negedge clk);
        bus.req_valid  = 1'b0;
        bus.req_wdata  = 64'hDEAD_BEEF_DEAD_BEEF;
        for (int k = 1; k <= lat; k++) begin
            chk({tag, "_both"}, {63'd0, bus.MemRead && bus.MemWrite}, 64'd0);
            if (bus.MemRead) nrd++;
            if (bus.MemWrite) begin
                nwr++;
                chk({tag, "_mwdat"}, bus.mem_wdata, exp_mwd);
            end
            if (bus.MemRead || bus.MemWrite)
                chk({tag, "_maddr"}, bus.mem_addr, {a[63:3], 3'b000});
            else
                chk({tag, "_maddr0"}, bus.mem_addr, 64'd0);
            chk({tag, "_rvld"}, {63'd0, bus.resp_valid}, {63'd0, k == lat});
            if (k == lat) begin
                chk({tag, "_rdata"}, bus.resp_rdata, exp_rdata);
                chk({tag, "_err"},   {63'd0, bus.resp_err}, {63'd0, exp_err});
            end
            @(negedge clk);
        end
        chk({tag, "_rvld_after"}, {63'd0, bus.resp_valid}, 64'd0);
        chk({tag, "_nrd"}, 64'(nrd), 64'(exp_rd));
        chk({tag, "_nwr"}, 64'(nwr), 64'(exp_wr));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 16; i++) mem[i] = 64'd0;
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 64'd0;
        bus.req_wdata  = 64'd0;

        #1 chk_idle_outputs("rst_pre_edge");
        @(posedge clk); #1;
        chk_idle_outputs("rst_post_edge");
        @(negedge clk);
        rst = 1'b0;
        #1 chk("ready_after_rst", {63'd0, bus.req_ready}, 64'd1);
        @(negedge clk);

        // SD then LD
        run("sd8",  1'b1, F3_D, 64'd8, 64'd12345, 2, 64'd0, 1'b0, 0, 1, 64'd12345);
        run("ld8",  1'b0, F3_D, 64'd8, 64'd0,     2, 64'd12345, 1'b0, 1, 0, 64'd0);

        // Sub-word read-modify-write
        run("sd16",  1'b1, F3_D,  64'd16, 64'd98765, 2, 64'd0, 1'b0, 0, 1, 64'h181CD);
        run("sb17",  1'b1, F3_B,  64'd17, 64'hAB,    3, 64'd0, 1'b0, 1, 1, 64'h1ABCD);
        run("lbu17", 1'b0, F3_BU, 64'd17, 64'd0,     2, 64'hAB, 1'b0, 1, 0, 64'd0);
        run("lb17",  1'b0, F3_B,  64'd17, 64'd0,     2, 64'hFFFF_FFFF_FFFF_FFAB, 1'b0, 1, 0, 64'd0);

        // Misaligned / illegal
        run("lw6",    1'b0, F3_W,  64'd6, 64'd0,    1, 64'd0, 1'b1, 0, 0, 64'd0);
        run("sh3",    1'b1, F3_H,  64'd3, 64'h55,   1, 64'd0, 1'b1, 0, 0, 64'd0);
        run("st_f4",  1'b1, F3_BU, 64'd0, 64'h77,   1, 64'd0, 1'b1, 0, 0, 64'd0);
        run("ld_f7",  1'b0, 3'b111, 64'd0, 64'd0,   1, 64'd0, 1'b1, 0, 0, 64'd0);

        // Sign/zero extension
        run("sw24",  1'b1, F3_W,  64'd24, 64'h8000_0000, 3, 64'd0, 1'b0, 1, 1, 64'h8000_0000);
        run("lw24",  1'b0, F3_W,  64'd24, 64'd0, 2, 64'hFFFF_FFFF_8000_0000, 1'b0, 1, 0, 64'd0);
        run("lwu24", 1'b0, F3_WU, 64'd24, 64'd0, 2, 64'h0000_0000_8000_0000, 1'b0, 1, 0, 64'd0);
        run("lh32",  1'b0, F3_H,  64'd32, 64'd0, 2, 64'd0, 1'b0, 1, 0, 64'd0);
        run("lhu18", 1'b0, F3_HU, 64'd18, 64'd0, 2, 64'd1, 1'b0, 1, 0, 64'd0);

        // Reset during the WR cycle of SH to 40
        chk("sh40_ready", {63'd0, bus.req_ready}, 64'd1);
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b1;
        bus.req_funct3 = F3_H;
        bus.req_addr   = 64'd40;
        bus.req_wdata  = 64'h1234;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("sh40_rd", {63'd0, bus.MemRead}, 64'd1);
        @(negedge clk);
        chk("sh40_wr", {63'd0, bus.MemWrite}, 64'd1);
        chk("sh40_wdat", bus.mem_wdata, 64'h1234);
        #2 rst = 1'b1;
        #1;
        chk_idle_outputs("sh40_abort");
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("sh40_no_resp", {63'd0, bus.resp_valid}, 64'd0);
            @(negedge clk);
        end
        run("ld40", 1'b0, F3_D, 64'd40, 64'd0, 2, 64'd0, 1'b0, 1, 0, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
